// File: rtl/add16_seq_pkg.sv
//==============================================================================
// Module : add16_seq_pkg
// Purpose: Definitions shared by the team's sequencer blocks. Holds the
//          three-state sequencer encoding, the default operand width in
//          nibbles, and the nibble width of the reused ripple adder.
// Ports  : none (package)
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package add16_seq_pkg;

  // Sequencer state encoding, shared by all team sequencers.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  localparam int NIBBLES_DEFAULT = 4;
  localparam int NIB_W           = 4;

endpackage : add16_seq_pkg

`default_nettype wire

// File: rtl/add16_seq_rca_4b.sv
//==============================================================================
// Module : rca_4b
// Purpose: 4-bit ripple-carry adder, built from a chain of full adders.
// Ports  : a_i, b_i  - 4-bit addends
//          c_i       - carry in
//          s_o       - 4-bit sum
//          c_o       - carry out of bit 3
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rca_4b
  import add16_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c_o
);

  logic [NIB_W:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[NIB_W];

endmodule : rca_4b

`default_nettype wire

// File: rtl/add16_seq.sv
//==============================================================================
// Module : add16_seq
// Purpose: 16-bit add/subtract that reuses one 4-bit ripple adder over four
//          cycles, least significant nibble first, with valid/ready
//          handshakes on both the operand and the result side.
// Ports  : clk, rst          - clock, synchronous active-high reset
//          in_valid/in_ready - operand handshake (ready only while IDLE)
//          A, B, sub         - operands; sub=1 computes A-B
//          out_valid/out_ready - result handshake
//          Sum, Cout, Ofl    - result, carry out (1 = no borrow on subtract),
//                              signed overflow
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module add16_seq
  import add16_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout,
  output logic                 Ofl
);

  localparam int W = 4 * NIBBLES;

  seq_state_t   state_q;
  logic [1:0]   cnt_q;
  logic         carry_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;       // B, already inverted when subtracting
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ofl_q;
  logic         out_valid_q;

  logic [3:0]       nib_base;
  logic [NIB_W-1:0] add_s;
  logic             add_co;

  assign nib_base = {cnt_q, 2'b00};

  // The single shared datapath adder; operands come from the latched nibble
  // selected by the nibble counter.
  rca_4b u_rca (
    .a_i (a_q[nib_base +: NIB_W]),
    .b_i (b_q[nib_base +: NIB_W]),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ofl_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B here and seed the carry.
            a_q     <= A;
            b_q     <= B ^ {W{sub}};
            carry_q <= sub;
            cnt_q   <= 2'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[nib_base +: NIB_W] <= add_s;
          carry_q                  <= add_co;
          if (cnt_q == 2'd3) begin
            // Last nibble: its sum bit 3 is the final Sum MSB.
            cout_q      <= add_co;
            ofl_q       <= (a_q[W-1] == b_q[W-1]) && (add_s[NIB_W-1] != a_q[W-1]);
            out_valid_q <= 1'b1;
            cnt_q       <= 2'd0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ofl       = ofl_q;

endmodule : add16_seq

`default_nettype wire

// File: tb/tb_add16_seq.sv
//==============================================================================
// Module : tb_add16_seq
// Purpose: Directed self-checking bench for add16_seq with hand-computed
//          expected results.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_add16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ofl;

  int n_vec = 0;
  int n_mis = 0;

  add16_seq #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ofl       (Ofl)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, four RUN cycles, check result, handshake out.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] e_sum, input logic e_c,
                        input logic e_o);
    chk({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    A = a; B = b; sub = s; in_valid = 1'b1;
    tick();                              // accept edge
    in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; sub = ~s;
    chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      chk({tag, " out_valid early"}, {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk({tag, " out_valid early"}, {31'd0, out_valid}, 32'd0);
    tick();                              // 4th edge after accept
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " Sum"},  {16'd0, Sum},     {16'd0, e_sum});
    chk({tag, " Cout"}, {31'd0, Cout},    {31'd0, e_c});
    chk({tag, " Ofl"},  {31'd0, Ofl},     {31'd0, e_o});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready back"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst Sum",       {16'd0, Sum},       32'd0);
    chk("rst Cout",      {31'd0, Cout},      32'd0);
    chk("rst Ofl",       {31'd0, Ofl},       32'd0);

    // Basic adds and subtracts
    run_op("add1234", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add7FFF", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub5m7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub0m0",  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-pressure in DONE while new operands are offered
    A = 16'h1234; B = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    tick();
    A = 16'hAAAA; B = 16'h5555; sub = 1'b0;   // held valid throughout
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp Sum",       {16'd0, Sum},       32'h2345);
      tick();
    end
    chk("bp Sum held", {16'd0, Sum}, 32'h2345);
    out_ready = 1'b1;
    tick();                                   // handshake edge: no accept
    out_ready = 1'b0;
    chk("bp idle in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp idle Sum",       {16'd0, Sum},       32'h2345);
    tick();                                   // accept edge for AAAA+5555
    in_valid = 1'b0;
    chk("bp accepted", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("bp2 out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp2 Sum",       {16'd0, Sum},       32'hFFFF);
    chk("bp2 Cout",      {31'd0, Cout},      32'd0);
    chk("bp2 Ofl",       {31'd0, Ofl},       32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in RUN with cnt=2
    A = 16'h1234; B = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    tick();                                   // accept, cnt=0
    in_valid = 1'b0;
    tick();                                   // cnt=1
    tick();                                   // cnt=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst Sum",       {16'd0, Sum},       32'd0);
    chk("midrst Cout",      {31'd0, Cout},      32'd0);
    run_op("add00FF", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Reset and in_valid together: nothing accepted
    A = 16'h4444; B = 16'h4444; sub = 1'b0; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstv in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("rstv out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstv still idle", {31'd0, in_ready}, 32'd1);
    chk("rstv Sum", {16'd0, Sum}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_add16_seq

`default_nettype wire
